// File: rtl/render_pkg.sv
`default_nettype none
// ============================================================================
// Module      : render_pkg
// Description : Shared types and constants for the render frame scheduler:
//               scheduler state encoding, packed particle record and the
//               default framebuffer geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package render_pkg;

  localparam int DEF_WIDTH  = 320;
  localparam int DEF_HEIGHT = 180;
  localparam int FB_PIXELS  = DEF_WIDTH * DEF_HEIGHT;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    FETCH   = 3'd2,
    MEMWAIT = 3'd3,
    ISSUE   = 3'd4,
    DRAIN   = 3'd5,
    DONE    = 3'd6
  } sched_state_t;

  // Particle BRAM word layout: {x[47:32], y[31:16], z[15:0]}
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } particle_t;

endpackage
`default_nettype wire

// File: rtl/fb_clear_counter.sv
`default_nettype none
// ============================================================================
// Module      : fb_clear_counter
// Description : Framebuffer clear address generator. A start pulse begins a
//               run of NUM_PIXELS write strobes at consecutive addresses
//               0..NUM_PIXELS-1, one per cycle.
// Ports       : clk      - system clock
//               rst      - synchronous active-high reset
//               i_start  - begin a clear run (restarts from address 0)
//               o_addr   - current clear address
//               o_valid  - clear write strobe
//               o_last   - high on the cycle carrying the final address
// Revision    : 1.0 - initial release
// ============================================================================
module fb_clear_counter
  import render_pkg::*;
#(
  parameter int NUM_PIXELS = FB_PIXELS,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_valid,
  output logic              o_last
);

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(NUM_PIXELS - 1);

  logic [ADDR_W-1:0] r_addr;
  logic              r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_valid <= 1'b0;
    end else if (i_start) begin
      r_addr  <= '0;
      r_valid <= 1'b1;
    end else if (r_valid) begin
      if (r_addr == c_last_addr) begin
        // Run complete: park the address at 0 so the port idles quietly.
        r_addr  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_addr <= r_addr + ADDR_W'(1);
      end
    end
  end

  assign o_addr  = r_addr;
  assign o_valid = r_valid;
  // Lets the owner leave its clear state on the same edge as the last strobe.
  assign o_last  = r_valid && (r_addr == c_last_addr);

endmodule
`default_nettype wire

// File: rtl/render_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : render_scheduler
// Description : Frame-level sequencer for the render pipeline. On a frame
//               start it clears the framebuffer to BG_COLOR, then streams the
//               particle memory into the render block one particle at a time
//               (throttled by render_ready_in plus a post-issue holdoff), and
//               finally pulses frame_done_out once the pipeline has drained.
// Ports       : clk_in, rst_in           - clock, synchronous active-high reset
//               frame_start_in           - new-frame request pulse
//               num_particles_in         - particle count (saturated to max)
//               mem_addr_out/mem_data_in - particle BRAM read port
//               render_ready_in          - render block ready level
//               render_idle_in           - render pipeline empty
//               f_x/f_y/f_z_out          - particle coordinates to render
//               data_valid_out           - particle issue strobe
//               clear_addr/color/valid   - framebuffer clear write port
//               busy_out                 - scheduler not idle
//               frame_done_out           - end-of-frame pulse
//               overrun_out              - frame start dropped while busy
// Revision    : 1.0 - initial release
// ============================================================================
module render_scheduler
  import render_pkg::*;
#(
  parameter int          WIDTH         = 320,
  parameter int          HEIGHT        = 180,
  parameter int          MAX_PARTICLES = 1024,
  parameter int          MEM_LATENCY   = 2,
  parameter int          READY_HOLDOFF = 3,
  parameter logic [15:0] BG_COLOR      = 16'h0000
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               frame_start_in,
  input  logic [$clog2(MAX_PARTICLES):0]     num_particles_in,
  output logic [$clog2(MAX_PARTICLES)-1:0]   mem_addr_out,
  input  logic [47:0]                        mem_data_in,
  input  logic                               render_ready_in,
  input  logic                               render_idle_in,
  output logic [15:0]                        f_x_out,
  output logic [15:0]                        f_y_out,
  output logic [15:0]                        f_z_out,
  output logic                               data_valid_out,
  output logic [15:0]                        clear_addr_out,
  output logic [15:0]                        clear_color_out,
  output logic                               clear_valid_out,
  output logic                               busy_out,
  output logic                               frame_done_out,
  output logic                               overrun_out
);

  localparam int c_addr_w    = $clog2(MAX_PARTICLES);
  localparam int c_cnt_w     = c_addr_w + 1;
  localparam int c_fb_pixels = WIDTH * HEIGHT;
  localparam int c_hold_w    = (READY_HOLDOFF > 0) ? $clog2(READY_HOLDOFF + 1) : 1;
  localparam int c_wait_w    = $clog2(MEM_LATENCY + 1);

  localparam logic [c_cnt_w-1:0]  c_max_count = c_cnt_w'(MAX_PARTICLES);
  localparam logic [c_hold_w-1:0] c_holdoff   = c_hold_w'(READY_HOLDOFF);
  localparam logic [c_wait_w-1:0] c_mem_lat   = c_wait_w'(MEM_LATENCY);

  sched_state_t        r_state;
  logic [c_cnt_w-1:0]  r_count;
  logic [c_addr_w-1:0] r_index;
  logic [c_hold_w-1:0] r_holdoff;
  logic [c_wait_w-1:0] r_wait;
  logic [15:0]         r_fx;
  logic [15:0]         r_fy;
  logic [15:0]         r_fz;
  logic                r_data_valid;
  logic                r_busy;
  logic                r_frame_done;
  logic                r_overrun;

  logic                w_clr_start;
  logic                w_clr_last;
  logic [c_cnt_w-1:0]  w_count_sat;
  logic                w_last_particle;
  logic                w_can_issue;
  particle_t           w_part;

  assign w_clr_start     = (r_state == IDLE) && frame_start_in;
  assign w_count_sat     = (num_particles_in > c_max_count) ? c_max_count : num_particles_in;
  assign w_last_particle = ({1'b0, r_index} == (r_count - c_cnt_w'(1)));
  assign w_can_issue     = render_ready_in && (r_holdoff == '0);
  assign w_part          = particle_t'(mem_data_in);

  fb_clear_counter #(
    .NUM_PIXELS (c_fb_pixels),
    .ADDR_W     (16)
  ) u_fb_clear_counter (
    .clk     (clk_in),
    .rst     (rst_in),
    .i_start (w_clr_start),
    .o_addr  (clear_addr_out),
    .o_valid (clear_valid_out),
    .o_last  (w_clr_last)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_index      <= '0;
      r_holdoff    <= '0;
      r_wait       <= '0;
      r_fx         <= '0;
      r_fy         <= '0;
      r_fz         <= '0;
      r_data_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_frame_done <= 1'b0;
      // Any start request outside IDLE (including the DONE cycle) is dropped.
      r_overrun    <= frame_start_in && (r_state != IDLE);

      // Holdoff runs down in every state; an issue below reloads it.
      if (r_holdoff != '0) begin
        r_holdoff <= r_holdoff - c_hold_w'(1);
      end

      case (r_state)
        IDLE: begin
          if (frame_start_in) begin
            r_count <= w_count_sat;
            r_index <= '0;
            r_busy  <= 1'b1;
            r_state <= CLEAR;
          end
        end

        CLEAR: begin
          if (w_clr_last) begin
            r_state <= (r_count == '0) ? DRAIN : FETCH;
          end
        end

        // mem_addr_out follows r_index, so this cycle presents the address.
        FETCH: begin
          r_wait  <= c_wait_w'(1);
          r_state <= MEMWAIT;
        end

        MEMWAIT: begin
          if (r_wait == c_mem_lat) begin
            r_fx    <= w_part.x;
            r_fy    <= w_part.y;
            r_fz    <= w_part.z;
            r_state <= ISSUE;
          end else begin
            r_wait <= r_wait + c_wait_w'(1);
          end
        end

        ISSUE: begin
          if (w_can_issue) begin
            r_data_valid <= 1'b1;
            r_holdoff    <= c_holdoff;
            if (w_last_particle) begin
              // Index is left on the last particle rather than wrapping.
              r_state <= DRAIN;
            end else begin
              r_index <= r_index + c_addr_w'(1);
              r_state <= FETCH;
            end
          end
        end

        DRAIN: begin
          if ((r_holdoff == '0) && render_idle_in && render_ready_in) begin
            r_frame_done <= 1'b1;
            r_state      <= DONE;
          end
        end

        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr_out    = r_index;
  assign f_x_out         = r_fx;
  assign f_y_out         = r_fy;
  assign f_z_out         = r_fz;
  assign data_valid_out  = r_data_valid;
  assign busy_out        = r_busy;
  assign frame_done_out  = r_frame_done;
  assign overrun_out     = r_overrun;
  assign clear_color_out = BG_COLOR;

endmodule
`default_nettype wire

// File: tb/tb_render_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_render_scheduler
// Description : Self-checking bench for render_scheduler using a reduced
//               framebuffer and particle capacity, randomized particle data
//               and handshake levels, and a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_render_scheduler;

  localparam int          TW      = 8;
  localparam int          TH      = 4;
  localparam int          TMAX    = 16;
  localparam int          TLAT    = 2;
  localparam int          THOLD   = 3;
  localparam logic [15:0] TBG     = 16'hA5C3;
  localparam int          PIXELS  = TW * TH;
  localparam int          MIN_GAP = ((THOLD + 1) > (TLAT + 2)) ? (THOLD + 1) : (TLAT + 2);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic [4:0]  num_particles = '0;
  logic [3:0]  mem_addr;
  logic [47:0] mem_data;
  logic        ready = 1'b0;
  logic        idle = 1'b0;
  logic [15:0] fx, fy, fz;
  logic        dv;
  logic [15:0] clr_addr, clr_color;
  logic        clr_valid, busy, done, ovr;

  render_scheduler #(
    .WIDTH(TW), .HEIGHT(TH), .MAX_PARTICLES(TMAX),
    .MEM_LATENCY(TLAT), .READY_HOLDOFF(THOLD), .BG_COLOR(TBG)
  ) dut (
    .clk_in(clk), .rst_in(rst), .frame_start_in(frame_start),
    .num_particles_in(num_particles), .mem_addr_out(mem_addr), .mem_data_in(mem_data),
    .render_ready_in(ready), .render_idle_in(idle),
    .f_x_out(fx), .f_y_out(fy), .f_z_out(fz), .data_valid_out(dv),
    .clear_addr_out(clr_addr), .clear_color_out(clr_color), .clear_valid_out(clr_valid),
    .busy_out(busy), .frame_done_out(done), .overrun_out(ovr)
  );

  always #5 clk = ~clk;

  // Particle BRAM model with TLAT cycles of read latency.
  logic [47:0] mem [TMAX];
  logic [47:0] bram_s1, bram_s2;
  always @(posedge clk) begin
    bram_s1 <= mem[mem_addr];
    bram_s2 <= bram_s1;
  end
  assign mem_data = bram_s2;

  // Observation of the output streams, sampled mid-cycle.
  int          cyc = 0;
  int          n_clr = 0, n_done = 0, n_ovr = 0;
  int          n_viol = 0;
  int          last_issue = -1000;
  logic        prev_dv = 1'b0, prev_cv = 1'b0, prev_ready = 1'b0, prev_idle = 1'b0;
  logic [15:0] prev_caddr = '0;
  logic [47:0] issued [$];

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (clr_valid) begin
        n_clr++;
        if (prev_cv ? (clr_addr != prev_caddr + 16'd1) : (clr_addr != 16'd0)) n_viol++;
      end
      if (clr_color !== TBG) n_viol++;
      if (dv) begin
        issued.push_back({fx, fy, fz});
        if (prev_dv) n_viol++;
        if (clr_valid) n_viol++;
        if (!prev_ready) n_viol++;
        if (cyc - last_issue < MIN_GAP) n_viol++;
        last_issue = cyc;
      end
      if (done) begin
        n_done++;
        if (!(prev_idle && prev_ready)) n_viol++;
        if (cyc - last_issue < THOLD + 1) n_viol++;
      end
      if (ovr) n_ovr++;
    end
    prev_dv    = dv;
    prev_cv    = clr_valid;
    prev_caddr = clr_addr;
    prev_ready = ready;
    prev_idle  = idle;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem_random();
    for (int i = 0; i < TMAX; i++) mem[i] = {16'($urandom), 16'($urandom), 16'($urandom)};
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dv"}, 64'(dv), 64'd0);
    chk({tag, "_clr_valid"}, 64'(clr_valid), 64'd0);
    chk({tag, "_clr_addr"}, 64'(clr_addr), 64'd0);
    chk({tag, "_clr_color"}, 64'(clr_color), 64'(TBG));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_ovr"}, 64'(ovr), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_fxyz"}, 64'({fx, fy, fz}), 64'd0);
  endtask

  // One full frame. hold_ready: ready/idle held high, else randomized.
  // extra_start: -1 none, -2 in the DONE cycle, k>=0 on frame cycle k.
  task automatic run_frame(input string tag, input int n, input bit hold_ready, input int extra_start);
    int base_clr, base_done, base_ovr, base_viol, base_iss, exp_iss, got_iss, k, clr_end;
    base_clr  = n_clr;
    base_done = n_done;
    base_ovr  = n_ovr;
    base_viol = n_viol;
    base_iss  = issued.size();
    exp_iss   = (n > TMAX) ? TMAX : n;

    frame_start   = 1'b1;
    num_particles = 5'(n);
    ready = 1'b1;
    idle  = 1'b1;
    tick();
    frame_start = 1'b0;
    chk({tag, "_busy_on"}, 64'(busy), 64'd1);

    k = 0;
    while (n_done == base_done && k < 5000) begin
      tick();
      frame_start = 1'b0;
      if (hold_ready) begin
        ready = 1'b1;
        idle  = 1'b1;
      end else begin
        ready = ($urandom_range(0, 3) != 0);
        idle  = ($urandom_range(0, 1) != 0);
      end
      if (extra_start == k) frame_start = 1'b1;
      if (extra_start == -2 && done === 1'b1) frame_start = 1'b1;
      k++;
    end
    frame_start = 1'b0;
    chk({tag, "_done_seen"}, 64'(n_done - base_done), 64'd1);
    tick();
    tick();
    chk({tag, "_busy_off"}, 64'(busy), 64'd0);
    chk({tag, "_clear_count"}, 64'(n_clr - base_clr), 64'(PIXELS));
    chk({tag, "_overrun"}, 64'(n_ovr - base_ovr), (extra_start == -1) ? 64'd0 : 64'd1);
    got_iss = issued.size() - base_iss;
    chk({tag, "_issue_count"}, 64'(got_iss), 64'(exp_iss));
    for (int i = 0; i < exp_iss && i < got_iss; i++) begin
      chk($sformatf("%s_issue%0d", tag, i), 64'(issued[base_iss + i]), 64'(mem[i]));
    end
    // No second frame may follow a dropped start.
    clr_end = n_clr;
    repeat (PIXELS + 8) tick();
    chk({tag, "_no_restart"}, 64'(n_clr - clr_end), 64'd0);
    chk({tag, "_stream_rules"}, 64'(n_viol - base_viol), 64'd0);
  endtask

  initial begin
    int base_iss, base_done, k;
    logic [47:0] held;

    fill_mem_random();
    rst = 1'b1;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Empty frame: clear only, then done once the pipeline is idle.
    run_frame("empty", 0, 1'b0, -1);

    // Three known particles, ready held high.
    for (int i = 0; i < TMAX; i++) mem[i] = {16'h0100 + 16'(i), 16'h0200 + 16'(i), 16'h0300 + 16'(i)};
    run_frame("three", 3, 1'b1, -1);

    // Randomized particle counts and handshakes.
    for (int f = 0; f < 4; f++) begin
      fill_mem_random();
      run_frame($sformatf("rand%0d", f), int'($urandom_range(1, TMAX)), 1'b0, -1);
    end

    // Dropped starts: during CLEAR and in the DONE cycle.
    fill_mem_random();
    run_frame("ovr_clear", 2, 1'b0, 5);
    run_frame("ovr_done", 1, 1'b1, -2);

    // Ready withheld for 50 cycles while the second particle waits.
    fill_mem_random();
    base_iss  = issued.size();
    base_done = n_done;
    frame_start = 1'b1; num_particles = 5'd2; ready = 1'b1; idle = 1'b1;
    tick();
    frame_start = 1'b0;
    k = 0;
    while (issued.size() == base_iss && k < 500) begin tick(); k++; end
    ready = 1'b0;
    held  = '0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (c == 10) held = {fx, fy, fz};
    end
    chk("stall_no_issue", 64'(issued.size() - base_iss), 64'd1);
    chk("stall_f_held", 64'({fx, fy, fz}), 64'(held));
    chk("stall_f_value", 64'(held), 64'(mem[1]));
    ready = 1'b1;
    k = 0;
    while (issued.size() == base_iss + 1 && k < 20) begin tick(); k++; end
    chk("stall_release_latency", 64'(k), 64'd2);
    chk("stall_issue_value", 64'(issued[issued.size() - 1]), 64'(mem[1]));
    k = 0;
    while (n_done == base_done && k < 100) begin tick(); k++; end
    chk("stall_done", 64'(n_done - base_done), 64'd1);
    repeat (3) tick();

    // Reset while the second particle is held in ISSUE.
    fill_mem_random();
    base_iss  = issued.size();
    frame_start = 1'b1; num_particles = 5'd5; ready = 1'b1; idle = 1'b1;
    tick();
    frame_start = 1'b0;
    k = 0;
    while (issued.size() == base_iss && k < 500) begin tick(); k++; end
    ready = 1'b0;
    repeat (8) tick();
    base_done = n_done;
    rst = 1'b1;
    tick();
    chk_reset_outputs("midreset");
    rst = 1'b0;
    ready = 1'b1;
    repeat (40) tick();
    chk("midreset_no_done", 64'(n_done - base_done), 64'd0);
    chk("midreset_issues", 64'(issued.size() - base_iss), 64'd1);
    run_frame("after_reset", 1, 1'b0, -1);

    // Count saturation at the particle memory capacity.
    fill_mem_random();
    run_frame("sat20", 20, 1'b1, -1);
    run_frame("sat31", 31, 1'b0, -1);
    run_frame("full16", 16, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
